rv_g_instdec: RTL and testbench
===============================

// Module: rv_g_instdec
// PURPOSE
//  Registered RV64G instruction decoder (RV64IMAFD + Zicsr + Zifencei). Takes a raw 32-bit
//  instruction word and produces a decoded command: the instruction identifier and every
//  operand field, with immediates already extracted. Sits between fetch and issue in the core.
//  One clock cycle of latency.
// PARAMETERS
//  decoded_instr_t  rv_g_pkg::decoded_instr_t  type of cmd_o; struct fields below.
//  XLEN             64                         architectural width; sets the shamt width (6 bits).
// PORTS
//  clk_i    in   1         clock; all state updates on the rising edge.
//  arst_ni  in   1         reset; asynchronous, active-low.
//  code_i   in   32        raw instruction word, sampled on every rising edge.
//  cmd_o    out  struct    registered decoded command.
// cmd_o fields:
//  func[7:0]  rv_g_pkg enum; INVALID = 0
//  rd, rs1, rs2, rs3  5b each; rs3 is R4-type [31:27]
//  imm[31:0]  sign-extended immediate
//  shamt[5:0]
//  pred[3:0], succ[3:0], fm[3:0]
//  csr[11:0]
//  aq, rl  1b each
//  rm[2:0]
// BEHAVIOUR
//  - Reset: while arst_ni=0, every cmd_o field is 0 (func=INVALID). This applies immediately,
//    independent of clk_i. The first decode is the first rising edge after release.
//  - Latency: cmd_o at edge N+1 reflects code_i sampled at edge N. There is no handshake;
//    the decoder accepts a new word every cycle.
//  - Decode is a pure function of code_i. Matching uses opcode[6:0], funct3, and
//    funct7/funct5/fmt/rs2 where the ISA needs them. Reserved encodings and code_i[1:0]!=2'b11
//    give func=INVALID with all fields 0.
//  - A field is populated only when the format uses it. Unused fields are forced to 0.
//  - R-type: rd, rs1, rs2.
//  - R4-type (FMADD/FMSUB/FNMSUB/FNMADD .S/.D): adds rs3 and rm=[14:12].
//  - I-type: imm = sext([31:20]).
//  - S-type: imm = sext({[31:25],[11:7]}).
//  - B-type: imm = sext({[31],[7],[30:25],[11:8],1'b0}).
//  - U-type: imm = {[31:12],12'b0}.
//  - J-type: imm = sext({[31],[19:12],[20],[30:21],1'b0}).
//  - Shifts: SLLI/SRLI/SRAI use shamt=[25:20] and require [31:26] to be 000000 or 010000.
//    *IW shifts use shamt={1'b0,[24:20]} and require [25]=0. For all shifts imm=0.
//  - FENCE: fm=[31:28], pred=[27:24], succ=[23:20], rd, rs1. FENCE.I gives imm=sext([31:20]).
//  - CSR ops: csr=[31:20]. CSRR*I forms put the zimm in the rs1 field.
//    ECALL/EBREAK are exact-word matches.
//  - AMO/LR/SC (.W/.D): aq=[26], rl=[25], rd, rs1, rs2. LR requires rs2=0.
//  - F/D arithmetic and conversions: rm=[14:12]. rm=101/110 is reserved and gives INVALID.
//    rm=111 (DYN) is legal. Single-operand ops need the fixed rs2 value.
//  - FP loads and stores use the I-type and S-type immediate rules respectively.
//  - Control: no FSM. Holding code_i constant holds cmd_o constant.
// TESTING
//  - Hold arst_ni=0, toggle clk_i and code_i -> cmd_o stays all-zero, func=INVALID.
//  - code_i=0x00000000 -> func=INVALID, all fields 0.
//  - 0x00500093 -> ADDI, rd=1, rs1=0, imm=5. 0xFFF00113 -> ADDI, rd=2, imm=0xFFFFFFFF.
//  - 0x123452B7 -> LUI, rd=5, imm=0x12345000.
//  - 0x0FF0000F -> FENCE, pred=0xF, succ=0xF, fm=0.
//    0x300110F3 -> CSRRW, rd=1, rs1=2, csr=0x300.
//  - Random code_i every cycle against a C reference model -> every field matches one cycle
//    later. Assert arst_ni mid-stream -> cmd_o clears with no clock edge required.

Source files
------------

// File: rtl/rv_g_instdec.sv
// Registered RV64G (IMAFD + Zicsr + Zifencei) instruction decoder: one raw word in per cycle,
// one fully decoded command out one cycle later, unused fields forced to zero.
package rv_g_pkg;

   typedef enum logic [7:0] {
      INVALID = 8'd0,
      LUI, AUIPC, JAL, JALR,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LD, LBU, LHU, LWU,
      SB, SH, SW, SD,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      ADDIW, SLLIW, SRLIW, SRAIW,
      ADDW, SUBW, SLLW, SRLW, SRAW,
      FENCE, FENCE_I, ECALL, EBREAK,
      CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
      MULW, DIVW, DIVUW, REMW, REMUW,
      LR_W, SC_W, AMOSWAP_W, AMOADD_W, AMOXOR_W, AMOAND_W, AMOOR_W,
      AMOMIN_W, AMOMAX_W, AMOMINU_W, AMOMAXU_W,
      LR_D, SC_D, AMOSWAP_D, AMOADD_D, AMOXOR_D, AMOAND_D, AMOOR_D,
      AMOMIN_D, AMOMAX_D, AMOMINU_D, AMOMAXU_D,
      FLW, FSW, FMADD_S, FMSUB_S, FNMSUB_S, FNMADD_S,
      FADD_S, FSUB_S, FMUL_S, FDIV_S, FSQRT_S, FSGNJ_S, FSGNJN_S, FSGNJX_S, FMIN_S, FMAX_S,
      FCVT_W_S, FCVT_WU_S, FMV_X_W, FEQ_S, FLT_S, FLE_S, FCLASS_S, FCVT_S_W, FCVT_S_WU,
      FMV_W_X, FCVT_L_S, FCVT_LU_S, FCVT_S_L, FCVT_S_LU,
      FLD, FSD, FMADD_D, FMSUB_D, FNMSUB_D, FNMADD_D,
      FADD_D, FSUB_D, FMUL_D, FDIV_D, FSQRT_D, FSGNJ_D, FSGNJN_D, FSGNJX_D, FMIN_D, FMAX_D,
      FCVT_S_D, FCVT_D_S, FEQ_D, FLT_D, FLE_D, FCLASS_D, FCVT_W_D, FCVT_WU_D, FCVT_D_W,
      FCVT_D_WU, FCVT_L_D, FCVT_LU_D, FMV_X_D, FCVT_D_L, FCVT_D_LU, FMV_D_X
   } func_e;

   typedef struct packed {
      func_e       func;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rs3;
      logic [31:0] imm;
      logic [5:0]  shamt;
      logic [3:0]  pred;
      logic [3:0]  succ;
      logic [3:0]  fm;
      logic [11:0] csr;
      logic        aq;
      logic        rl;
      logic [2:0]  rm;
   } decoded_instr_t;

endpackage

module rv_g_instdec #(
   parameter type decoded_instr_t = rv_g_pkg::decoded_instr_t,
   parameter int  XLEN            = 64
) (
   input  logic           clk_i,
   input  logic           arst_ni,
   input  logic [31:0]    code_i,
   output decoded_instr_t cmd_o
);
   import rv_g_pkg::*;

   localparam int SHAMT_W = $clog2(XLEN);

   typedef enum logic [3:0] {
      FMT_NONE, FMT_R, FMT_R4, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J,
      FMT_SH, FMT_SHW, FMT_FENCE, FMT_CSR, FMT_AMO, FMT_FRM, FMT_F1RM, FMT_F1
   } fmt_e;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  f5;
   logic [4:0]  rs2f;
   logic        sp;
   logic        dw;
   logic        rm_ok;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   func_e          func_sel;
   fmt_e           fmt_sel;
   decoded_instr_t cmd_d, cmd_q;

   assign opc   = code_i[6:0];
   assign f3    = code_i[14:12];
   assign f7    = code_i[31:25];
   assign f5    = code_i[31:27];
   assign rs2f  = code_i[24:20];
   assign sp    = ~code_i[25];
   assign dw    = code_i[12];
   assign rm_ok = (f3 != 3'b101) && (f3 != 3'b110);

   assign imm_i = {{20{code_i[31]}}, code_i[31:20]};
   assign imm_s = {{20{code_i[31]}}, code_i[31:25], code_i[11:7]};
   assign imm_b = {{19{code_i[31]}}, code_i[31], code_i[7], code_i[30:25], code_i[11:8], 1'b0};
   assign imm_u = {code_i[31:12], 12'b0};
   assign imm_j = {{11{code_i[31]}}, code_i[31], code_i[19:12], code_i[20], code_i[30:21], 1'b0};

   // Stage 1: identify the instruction and which operand format it carries.
   always_comb begin
      func_sel = INVALID;
      fmt_sel  = FMT_NONE;
      case (opc)
         7'b0110111: begin func_sel = LUI;   fmt_sel = FMT_U; end
         7'b0010111: begin func_sel = AUIPC; fmt_sel = FMT_U; end
         7'b1101111: begin func_sel = JAL;   fmt_sel = FMT_J; end
         7'b1100111: if (f3 == 3'b000) begin func_sel = JALR; fmt_sel = FMT_I; end
         7'b1100011: begin
            fmt_sel = FMT_B;
            case (f3)
               3'b000: func_sel = BEQ;
               3'b001: func_sel = BNE;
               3'b100: func_sel = BLT;
               3'b101: func_sel = BGE;
               3'b110: func_sel = BLTU;
               3'b111: func_sel = BGEU;
               default: ;
            endcase
         end
         7'b0000011: begin
            fmt_sel = FMT_I;
            case (f3)
               3'b000: func_sel = LB;
               3'b001: func_sel = LH;
               3'b010: func_sel = LW;
               3'b011: func_sel = LD;
               3'b100: func_sel = LBU;
               3'b101: func_sel = LHU;
               3'b110: func_sel = LWU;
               default: ;
            endcase
         end
         7'b0100011: begin
            fmt_sel = FMT_S;
            case (f3)
               3'b000: func_sel = SB;
               3'b001: func_sel = SH;
               3'b010: func_sel = SW;
               3'b011: func_sel = SD;
               default: ;
            endcase
         end
         7'b0010011: begin
            fmt_sel = FMT_I;
            case (f3)
               3'b000: func_sel = ADDI;
               3'b010: func_sel = SLTI;
               3'b011: func_sel = SLTIU;
               3'b100: func_sel = XORI;
               3'b110: func_sel = ORI;
               3'b111: func_sel = ANDI;
               3'b001: begin
                  fmt_sel = FMT_SH;
                  if (code_i[31:26] == 6'b000000) func_sel = SLLI;
               end
               default: begin
                  fmt_sel = FMT_SH;
                  if (code_i[31:26] == 6'b000000)      func_sel = SRLI;
                  else if (code_i[31:26] == 6'b010000) func_sel = SRAI;
               end
            endcase
         end
         7'b0011011: begin
            fmt_sel = FMT_SHW;
            case (f3)
               3'b000: begin func_sel = ADDIW; fmt_sel = FMT_I; end
               3'b001: if (f7 == 7'b0000000) func_sel = SLLIW;
               3'b101: begin
                  if (f7 == 7'b0000000)      func_sel = SRLIW;
                  else if (f7 == 7'b0100000) func_sel = SRAIW;
               end
               default: ;
            endcase
         end
         7'b0110011: begin
            fmt_sel = FMT_R;
            case ({f7, f3})
               10'b0000000_000: func_sel = ADD;
               10'b0000000_001: func_sel = SLL;
               10'b0000000_010: func_sel = SLT;
               10'b0000000_011: func_sel = SLTU;
               10'b0000000_100: func_sel = XOR;
               10'b0000000_101: func_sel = SRL;
               10'b0000000_110: func_sel = OR;
               10'b0000000_111: func_sel = AND;
               10'b0100000_000: func_sel = SUB;
               10'b0100000_101: func_sel = SRA;
               10'b0000001_000: func_sel = MUL;
               10'b0000001_001: func_sel = MULH;
               10'b0000001_010: func_sel = MULHSU;
               10'b0000001_011: func_sel = MULHU;
               10'b0000001_100: func_sel = DIV;
               10'b0000001_101: func_sel = DIVU;
               10'b0000001_110: func_sel = REM;
               10'b0000001_111: func_sel = REMU;
               default: ;
            endcase
         end
         7'b0111011: begin
            fmt_sel = FMT_R;
            case ({f7, f3})
               10'b0000000_000: func_sel = ADDW;
               10'b0000000_001: func_sel = SLLW;
               10'b0000000_101: func_sel = SRLW;
               10'b0100000_000: func_sel = SUBW;
               10'b0100000_101: func_sel = SRAW;
               10'b0000001_000: func_sel = MULW;
               10'b0000001_100: func_sel = DIVW;
               10'b0000001_101: func_sel = DIVUW;
               10'b0000001_110: func_sel = REMW;
               10'b0000001_111: func_sel = REMUW;
               default: ;
            endcase
         end
         7'b0001111: begin
            if (f3 == 3'b000)      begin func_sel = FENCE;   fmt_sel = FMT_FENCE; end
            else if (f3 == 3'b001) begin func_sel = FENCE_I; fmt_sel = FMT_I;     end
         end
         7'b1110011: begin
            fmt_sel = FMT_CSR;
            case (f3)
               3'b000: begin
                  fmt_sel = FMT_NONE;
                  if (code_i == 32'h0000_0073)      func_sel = ECALL;
                  else if (code_i == 32'h0010_0073) func_sel = EBREAK;
               end
               3'b001: func_sel = CSRRW;
               3'b010: func_sel = CSRRS;
               3'b011: func_sel = CSRRC;
               3'b101: func_sel = CSRRWI;
               3'b110: func_sel = CSRRSI;
               3'b111: func_sel = CSRRCI;
               default: ;
            endcase
         end
         7'b0101111: if (f3 == 3'b010 || f3 == 3'b011) begin
            fmt_sel = FMT_AMO;
            case (f5)
               5'b00010: if (rs2f == 5'd0) func_sel = dw ? LR_D : LR_W;
               5'b00011: func_sel = dw ? SC_D      : SC_W;
               5'b00001: func_sel = dw ? AMOSWAP_D : AMOSWAP_W;
               5'b00000: func_sel = dw ? AMOADD_D  : AMOADD_W;
               5'b00100: func_sel = dw ? AMOXOR_D  : AMOXOR_W;
               5'b01100: func_sel = dw ? AMOAND_D  : AMOAND_W;
               5'b01000: func_sel = dw ? AMOOR_D   : AMOOR_W;
               5'b10000: func_sel = dw ? AMOMIN_D  : AMOMIN_W;
               5'b10100: func_sel = dw ? AMOMAX_D  : AMOMAX_W;
               5'b11000: func_sel = dw ? AMOMINU_D : AMOMINU_W;
               5'b11100: func_sel = dw ? AMOMAXU_D : AMOMAXU_W;
               default: ;
            endcase
         end
         7'b0000111: begin
            fmt_sel = FMT_I;
            if (f3 == 3'b010)      func_sel = FLW;
            else if (f3 == 3'b011) func_sel = FLD;
         end
         7'b0100111: begin
            fmt_sel = FMT_S;
            if (f3 == 3'b010)      func_sel = FSW;
            else if (f3 == 3'b011) func_sel = FSD;
         end
         7'b1000011: if (!code_i[26] && rm_ok) begin func_sel = sp ? FMADD_S  : FMADD_D;  fmt_sel = FMT_R4; end
         7'b1000111: if (!code_i[26] && rm_ok) begin func_sel = sp ? FMSUB_S  : FMSUB_D;  fmt_sel = FMT_R4; end
         7'b1001011: if (!code_i[26] && rm_ok) begin func_sel = sp ? FNMSUB_S : FNMSUB_D; fmt_sel = FMT_R4; end
         7'b1001111: if (!code_i[26] && rm_ok) begin func_sel = sp ? FNMADD_S : FNMADD_D; fmt_sel = FMT_R4; end
         // Only fmt S (00) and D (01) exist in RV64G, hence the bit-26 gate.
         7'b1010011: if (!code_i[26]) begin
            case (f5)
               5'b00000: if (rm_ok) begin func_sel = sp ? FADD_S : FADD_D; fmt_sel = FMT_FRM; end
               5'b00001: if (rm_ok) begin func_sel = sp ? FSUB_S : FSUB_D; fmt_sel = FMT_FRM; end
               5'b00010: if (rm_ok) begin func_sel = sp ? FMUL_S : FMUL_D; fmt_sel = FMT_FRM; end
               5'b00011: if (rm_ok) begin func_sel = sp ? FDIV_S : FDIV_D; fmt_sel = FMT_FRM; end
               5'b01011: if (rm_ok && rs2f == 5'd0) begin
                  func_sel = sp ? FSQRT_S : FSQRT_D;
                  fmt_sel  = FMT_F1RM;
               end
               5'b00100: begin
                  fmt_sel = FMT_R;
                  case (f3)
                     3'b000: func_sel = sp ? FSGNJ_S  : FSGNJ_D;
                     3'b001: func_sel = sp ? FSGNJN_S : FSGNJN_D;
                     3'b010: func_sel = sp ? FSGNJX_S : FSGNJX_D;
                     default: ;
                  endcase
               end
               5'b00101: begin
                  fmt_sel = FMT_R;
                  if (f3 == 3'b000)      func_sel = sp ? FMIN_S : FMIN_D;
                  else if (f3 == 3'b001) func_sel = sp ? FMAX_S : FMAX_D;
               end
               5'b01000: begin
                  fmt_sel = FMT_F1RM;
                  if (rm_ok && sp && rs2f == 5'd1)       func_sel = FCVT_S_D;
                  else if (rm_ok && !sp && rs2f == 5'd0) func_sel = FCVT_D_S;
               end
               5'b10100: begin
                  fmt_sel = FMT_R;
                  case (f3)
                     3'b010: func_sel = sp ? FEQ_S : FEQ_D;
                     3'b001: func_sel = sp ? FLT_S : FLT_D;
                     3'b000: func_sel = sp ? FLE_S : FLE_D;
                     default: ;
                  endcase
               end
               5'b11000: begin
                  fmt_sel = FMT_F1RM;
                  if (rm_ok) case (rs2f)
                     5'd0: func_sel = sp ? FCVT_W_S  : FCVT_W_D;
                     5'd1: func_sel = sp ? FCVT_WU_S : FCVT_WU_D;
                     5'd2: func_sel = sp ? FCVT_L_S  : FCVT_L_D;
                     5'd3: func_sel = sp ? FCVT_LU_S : FCVT_LU_D;
                     default: ;
                  endcase
               end
               5'b11010: begin
                  fmt_sel = FMT_F1RM;
                  if (rm_ok) case (rs2f)
                     5'd0: func_sel = sp ? FCVT_S_W  : FCVT_D_W;
                     5'd1: func_sel = sp ? FCVT_S_WU : FCVT_D_WU;
                     5'd2: func_sel = sp ? FCVT_S_L  : FCVT_D_L;
                     5'd3: func_sel = sp ? FCVT_S_LU : FCVT_D_LU;
                     default: ;
                  endcase
               end
               5'b11100: begin
                  fmt_sel = FMT_F1;
                  if (rs2f == 5'd0 && f3 == 3'b000)      func_sel = sp ? FMV_X_W  : FMV_X_D;
                  else if (rs2f == 5'd0 && f3 == 3'b001) func_sel = sp ? FCLASS_S : FCLASS_D;
               end
               5'b11110: begin
                  fmt_sel = FMT_F1;
                  if (rs2f == 5'd0 && f3 == 3'b000) func_sel = sp ? FMV_W_X : FMV_D_X;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Stage 2: copy out only the fields the format owns; INVALID leaves everything zero.
   always_comb begin
      cmd_d = '0;
      if (func_sel != INVALID) begin
         cmd_d.func = func_sel;
         case (fmt_sel)
            FMT_R:     begin cmd_d.rd = code_i[11:7]; cmd_d.rs1 = code_i[19:15]; cmd_d.rs2 = rs2f; end
            FMT_R4:    begin
               cmd_d.rd  = code_i[11:7];
               cmd_d.rs1 = code_i[19:15];
               cmd_d.rs2 = rs2f;
               cmd_d.rs3 = f5;
               cmd_d.rm  = f3;
            end
            FMT_I:     begin cmd_d.rd = code_i[11:7]; cmd_d.rs1 = code_i[19:15]; cmd_d.imm = imm_i; end
            FMT_S:     begin cmd_d.rs1 = code_i[19:15]; cmd_d.rs2 = rs2f; cmd_d.imm = imm_s; end
            FMT_B:     begin cmd_d.rs1 = code_i[19:15]; cmd_d.rs2 = rs2f; cmd_d.imm = imm_b; end
            FMT_U:     begin cmd_d.rd = code_i[11:7]; cmd_d.imm = imm_u; end
            FMT_J:     begin cmd_d.rd = code_i[11:7]; cmd_d.imm = imm_j; end
            FMT_SH:    begin
               cmd_d.rd    = code_i[11:7];
               cmd_d.rs1   = code_i[19:15];
               cmd_d.shamt = 6'(code_i[20 +: SHAMT_W]);
            end
            FMT_SHW:   begin cmd_d.rd = code_i[11:7]; cmd_d.rs1 = code_i[19:15]; cmd_d.shamt = {1'b0, rs2f}; end
            FMT_FENCE: begin
               cmd_d.rd   = code_i[11:7];
               cmd_d.rs1  = code_i[19:15];
               cmd_d.fm   = code_i[31:28];
               cmd_d.pred = code_i[27:24];
               cmd_d.succ = code_i[23:20];
            end
            FMT_CSR:   begin cmd_d.rd = code_i[11:7]; cmd_d.rs1 = code_i[19:15]; cmd_d.csr = code_i[31:20]; end
            FMT_AMO:   begin
               cmd_d.rd  = code_i[11:7];
               cmd_d.rs1 = code_i[19:15];
               cmd_d.rs2 = rs2f;
               cmd_d.aq  = code_i[26];
               cmd_d.rl  = code_i[25];
            end
            FMT_FRM:   begin
               cmd_d.rd  = code_i[11:7];
               cmd_d.rs1 = code_i[19:15];
               cmd_d.rs2 = rs2f;
               cmd_d.rm  = f3;
            end
            FMT_F1RM:  begin cmd_d.rd = code_i[11:7]; cmd_d.rs1 = code_i[19:15]; cmd_d.rm = f3; end
            FMT_F1:    begin cmd_d.rd = code_i[11:7]; cmd_d.rs1 = code_i[19:15]; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) cmd_q <= '0;
      else          cmd_q <= cmd_d;
   end

   assign cmd_o = cmd_q;

endmodule

// File: tb/tb_rv_g_instdec.sv
// Directed-vector bench for rv_g_instdec: the stimulus queues the expected command per word,
// an independent monitor pops and compares one cycle later; async reset is probed between edges.
module tb_rv_g_instdec;
   import rv_g_pkg::*;

   typedef struct {
      logic [31:0]    code;
      decoded_instr_t exp;
   } txn_t;

   logic           clk_i = 1'b0;
   logic           arst_ni;
   logic [31:0]    code_i;
   decoded_instr_t cmd_o;

   txn_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   async_req = 0;
   bit   stim_done = 1'b0;
   event async_ev;

   always #5 clk_i = ~clk_i;

   rv_g_instdec dut (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .code_i  (code_i),
      .cmd_o   (cmd_o)
   );

   function automatic decoded_instr_t mk(input func_e f, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
      decoded_instr_t r;
      r      = '0;
      r.func = f;
      r.rd   = rd;
      r.rs1  = rs1;
      r.rs2  = rs2;
      r.imm  = imm;
      return r;
   endfunction

   task automatic send(input logic [31:0] c, input decoded_instr_t x);
      txn_t t;
      @(negedge clk_i);
      code_i = c;
      t.code = c;
      t.exp  = x;
      sb_q.push_back(t);
   endtask

   // Monitor: the only process that steps the check counters.
   initial begin : monitor
      txn_t  t;
      func_e f;
      int    async_seen;
      async_seen = 0;
      forever begin
         @(posedge clk_i or async_ev);
         #1;
         if (async_req != async_seen) begin
            async_seen = async_req;
            n_checks++;
            if (cmd_o !== '0) begin
               n_errors++;
               $display("FAIL async_clear: cmd_o=%h required=0", cmd_o);
            end else begin
               $display("ok   async_clear: cmd_o=0 without clock edge");
            end
         end else if (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            f = t.exp.func;
            n_checks++;
            if (cmd_o !== t.exp) begin
               n_errors++;
               $display("FAIL decode %s code=%h: cmd_o=%h required=%h", f.name(), t.code, cmd_o, t.exp);
            end else begin
               $display("ok   decode %s code=%h cmd_o=%h", f.name(), t.code, cmd_o);
            end
         end else if (stim_done) begin
            $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
            $finish;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      decoded_instr_t e;
      arst_ni = 1'b1;
      code_i  = '0;
      #1 arst_ni = 1'b0;

      // Held in reset: clock and code toggle, output must stay zero.
      send(32'h0050_0093, '0);
      send(32'h1234_52B7, '0);
      send(32'h3001_10F3, '0);
      send(32'hFFFF_FFFF, '0);

      @(negedge clk_i);
      arst_ni = 1'b1;

      send(32'h0000_0000, '0);
      send(32'h0050_0091, '0);
      send(32'h0050_0093, mk(ADDI, 5'd1, 5'd0, 5'd0, 32'h0000_0005));
      send(32'hFFF0_0113, mk(ADDI, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF));
      send(32'hFFF1_3083, mk(LD,   5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF));
      send(32'hFFFF_F097, mk(AUIPC, 5'd1, 5'd0, 5'd0, 32'hFFFF_F000));
      send(32'h0010_00EF, mk(JAL,  5'd1, 5'd0, 5'd0, 32'h0000_0800));
      send(32'hFE20_AE23, mk(SW,   5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC));
      send(32'hFE20_8CE3, mk(BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8));
      send(32'h0020_81B3, mk(ADD,  5'd3, 5'd1, 5'd2, 32'h0));
      send(32'h4020_81B3, mk(SUB,  5'd3, 5'd1, 5'd2, 32'h0));
      send(32'h2020_81B3, '0);
      send(32'h0294_53BB, mk(DIVUW, 5'd7, 5'd8, 5'd9, 32'h0));

      e = mk(SRAI, 5'd5, 5'd6, 5'd0, 32'h0);  e.shamt = 6'd63;
      send(32'h43F3_5293, e);
      e = mk(SRAIW, 5'd5, 5'd6, 5'd0, 32'h0); e.shamt = 6'd31;
      send(32'h41F3_529B, e);
      send(32'h0203_129B, '0);

      e = '0; e.func = FENCE; e.pred = 4'hF; e.succ = 4'hF;
      send(32'h0FF0_000F, e);
      send(32'h0000_100F, mk(FENCE_I, 5'd0, 5'd0, 5'd0, 32'h0));

      e = mk(CSRRW, 5'd1, 5'd2, 5'd0, 32'h0);  e.csr = 12'h300;
      send(32'h3001_10F3, e);
      e = mk(CSRRSI, 5'd0, 5'd5, 5'd0, 32'h0); e.csr = 12'h300;
      send(32'h3002_E073, e);
      send(32'h0010_0073, mk(EBREAK, 5'd0, 5'd0, 5'd0, 32'h0));
      send(32'h0020_0073, '0);

      e = mk(AMOADD_D, 5'd5, 5'd10, 5'd11, 32'h0); e.aq = 1'b1;
      send(32'h04B5_32AF, e);
      e = mk(LR_W, 5'd5, 5'd10, 5'd0, 32'h0);      e.rl = 1'b1;
      send(32'h1205_22AF, e);
      send(32'h1015_22AF, '0);

      e = mk(FMADD_D, 5'd1, 5'd2, 5'd3, 32'h0); e.rs3 = 5'd4; e.rm = 3'd7;
      send(32'h2231_70C3, e);
      send(32'h0031_00D3, mk(FADD_S, 5'd1, 5'd2, 5'd3, 32'h0));
      send(32'h0031_50D3, '0);
      e = mk(FCVT_L_D, 5'd10, 5'd2, 5'd0, 32'h0); e.rm = 3'd1;
      send(32'hC221_1553, e);
      send(32'h5811_00D3, '0);
      send(32'hE202_11D3, mk(FCLASS_D, 5'd3, 5'd4, 5'd0, 32'h0));
      send(32'h0081_2087, mk(FLW, 5'd1, 5'd2, 5'd0, 32'h0000_0008));

      // Hold a non-zero result, then pull reset between clock edges.
      send(32'h1234_52B7, mk(LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000));
      repeat (3) @(posedge clk_i);
      #3;
      arst_ni = 1'b0;
      async_req++;
      -> async_ev;
      #3;
      @(negedge clk_i);
      arst_ni = 1'b1;

      send(32'h0050_0093, mk(ADDI, 5'd1, 5'd0, 5'd0, 32'h0000_0005));
      stim_done = 1'b1;
   end

endmodule
